// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake on both sides.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_width
    $fatal(1, "cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
  end
  if (GROUP != 2 && GROUP != 4 && GROUP != 8) begin : g_bad_group
    $fatal(1, "cla_pipe_adder: GROUP must be 2, 4 or 8");
  end

  logic             s1_valid;
  logic             s2_free;
  logic             accept;
  logic             advance;

  logic [WIDTH-1:0] p_d, g_d, p_q, g_q;
  logic [NG-1:0]    gp_d, gg_d, gp_q, gg_q;
  logic             cin_q;

  logic [NG:0]      gc;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;

  assign s2_free  = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_free;
  assign accept   = in_valid & in_ready;
  assign advance  = s1_valid & s2_free;

  // Stage 1: bit and group propagate/generate.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    p_d  = a ^ b;
    g_d  = a & b;
    gp_d = '0;
    gg_d = '0;
    for (int k = 0; k < NG; k++) begin
      gp_d[k] = &p_d[k*GROUP +: GROUP];
      acc = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
        acc = g_d[k*GROUP+i] | (p_d[k*GROUP+i] & acc);
      end
      gg_d[k] = acc;
    end
  end

  // Stage 2: each group carry is a flat sum of products over the registered G/P terms.
  always_comb begin
    logic term, pchain, carry;
    term   = 1'b0;
    pchain = 1'b1;
    carry  = 1'b0;
    gc     = '0;
    c      = '0;
    gc[0]  = cin_q;
    for (int k = 1; k <= NG; k++) begin
      term   = 1'b0;
      pchain = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        term   = term | (gg_q[j] & pchain);
        pchain = pchain & gp_q[j];
      end
      gc[k] = term | (cin_q & pchain);
    end
    for (int k = 0; k < NG; k++) begin
      carry = gc[k];
      for (int i = 0; i < GROUP; i++) begin
        c[k*GROUP+i] = carry;
        carry = g_q[k*GROUP+i] | (p_q[k*GROUP+i] & carry);
      end
    end
    c[WIDTH] = gc[NG];
    sum_d    = p_q ^ c[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      p_q      <= '0;
      g_q      <= '0;
      gp_q     <= '0;
      gg_q     <= '0;
      cin_q    <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        p_q      <= p_d;
        g_q      <= g_d;
        gp_q     <= gp_d;
        gg_q     <= gg_d;
        cin_q    <= cin;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= 1'b1;
        sum       <= sum_d;
        cout      <= c[WIDTH];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CLA_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (advance) begin
      ovf <= c[WIDTH-1] ^ c[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed 8-bit cases plus random 16/4 and 32/8 streams.
// Checks ovf as well when CLA_OVF_EN is defined.
module tb_cla_pipe_adder;

  localparam int unsigned NRAND = 10000;
`ifdef CLA_OVF_EN
  localparam logic [63:0] CMP_MASK = 64'h3_FFFF_FFFF;
`else
  localparam logic [63:0] CMP_MASK = 64'h1_FFFF_FFFF;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8, c8, co8, of8;
  logic [7:0]  a8, b8, s8;
  logic        iv16, ir16, ov16, or16, c16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv32, ir32, ov32, or32, c32, co32, of32;
  logic [31:0] a32, b32, s32;

`ifndef CLA_OVF_EN
  assign of8  = 1'b0;
  assign of16 = 1'b0;
  assign of32 = 1'b0;
`endif

  cla_pipe_adder #(.WIDTH(8), .GROUP(4)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef CLA_OVF_EN
    , .ovf(of8)
`endif
  );

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(c16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16)
`ifdef CLA_OVF_EN
    , .ovf(of16)
`endif
  );

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(c32),
    .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32)
`ifdef CLA_OVF_EN
    , .ovf(of32)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer addition and the signed-overflow rule.
  function automatic logic [63:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic ci);
    logic [63:0] full, r;
    logic [63:0] mask;
    full = 64'(x) + 64'(y) + 64'(ci);
    mask = (64'd1 << w) - 64'd1;
    r = '0;
    r[31:0] = 32'(full & mask);
    r[32] = full[w];
    r[33] = (x[w-1] == y[w-1]) && (full[w-1] != x[w-1]);
    return r & CMP_MASK;
  endfunction

  function automatic logic [63:0] pack(input logic [31:0] s, input logic co, input logic of);
    return {30'b0, of, co, s} & CMP_MASK;
  endfunction

  // One isolated transaction on the 8-bit DUT with exact latency checks.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic ci, input string tag);
    @(negedge clk);
    iv8 = 1'b1; a8 = x; b8 = y; c8 = ci; or8 = 1'b1;
    #1 check({tag, "_in_ready"}, 64'(ir8), 64'd1);
    @(negedge clk);
    iv8 = 1'b0;
    #1 check({tag, "_lat1_invalid"}, 64'(ov8), 64'd0);
    @(negedge clk);
    #1 check({tag, "_out_valid"}, 64'(ov8), 64'd1);
    check({tag, "_result"}, pack(32'(s8), co8, of8), ref_add(8, 32'(x), 32'(y), ci));
    @(negedge clk);
    #1 check({tag, "_one_cycle"}, 64'(ov8), 64'd0);
  endtask

  logic [16:0] pairs [4];
  logic [63:0] q16 [$];
  logic [63:0] q32 [$];

  initial begin
    int sent, rcv;
    int sent16, rcv16, sent32, rcv32, cyc;
    logic [63:0] e;

    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; c8 = 0; or8 = 0;
    iv16 = 0; a16 = 0; b16 = 0; c16 = 0; or16 = 0;
    iv32 = 0; a32 = 0; b32 = 0; c32 = 0; or32 = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(ov8), 64'd0);
    check("rst_result", pack(32'(s8), co8, of8), 64'd0);
    check("rst_in_ready", 64'(ir8), 64'd1);
    rst = 1'b0;

    run8(8'hFF, 8'h01, 1'b0, "ff_plus_1");
    run8(8'h0F, 8'hF0, 1'b1, "xgroup_cin1");
    run8(8'h0F, 8'hF0, 1'b0, "xgroup_cin0");
    run8(8'h7F, 8'h01, 1'b0, "ovf_7f_01");
    run8(8'h80, 8'h80, 1'b0, "ovf_80_80");
    run8(8'h7F, 8'h80, 1'b0, "ovf_7f_80");
    run8(8'hA5, 8'h5A, 1'b1, "a5_5a_cin");

    // Backpressure: four back-to-back operands, consumer stalled for the first five cycles.
    pairs[0] = {8'h12, 8'h34, 1'b0};
    pairs[1] = {8'hF0, 8'h20, 1'b1};
    pairs[2] = {8'h80, 8'h7F, 1'b1};
    pairs[3] = {8'h55, 8'hAA, 1'b0};
    sent = 0;
    rcv = 0;
    for (int t = 0; t < 40 && rcv < 4; t++) begin
      @(negedge clk);
      or8 = (t >= 5);
      iv8 = (sent < 4);
      if (sent < 4) {a8, b8, c8} = pairs[sent];
      #1;
      if (t == 2) begin
        check("bp_in_ready_drop", 64'(ir8), 64'd0);
        check("bp_accepts_before_full", 64'(sent), 64'd2);
      end
      if (t >= 2 && t <= 4) begin
        check("bp_hold_valid", 64'(ov8), 64'd1);
        check("bp_hold_result", pack(32'(s8), co8, of8),
              ref_add(8, 32'(pairs[0][16:9]), 32'(pairs[0][8:1]), pairs[0][0]));
      end
      if (ov8 && or8) begin
        check("bp_order", pack(32'(s8), co8, of8),
              ref_add(8, 32'(pairs[rcv][16:9]), 32'(pairs[rcv][8:1]), pairs[rcv][0]));
        rcv++;
      end
      if (iv8 && ir8) sent++;
    end
    check("bp_all_results", 64'(rcv), 64'd4);

    // Reset with both stages occupied.
    @(negedge clk);
    iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; c8 = 1'b0; or8 = 1'b0;
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44;
    @(negedge clk);
    iv8 = 1'b0;
    #1 check("rst_mid_pre_full", 64'(ov8 & !ir8), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(ov8), 64'd0);
    check("rst_mid_result", pack(32'(s8), co8, of8), 64'd0);
    check("rst_mid_in_ready", 64'(ir8), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run8(8'h3C, 8'h4B, 1'b1, "post_rst");

    // Random streams on the wider configurations, running side by side.
    sent16 = 0; rcv16 = 0; sent32 = 0; rcv32 = 0;
    cyc = 0;
    while ((rcv16 < NRAND || rcv32 < NRAND) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      iv16 = (sent16 < NRAND) && ($urandom_range(0, 3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      or16 = ($urandom_range(0, 3) != 0);
      iv32 = (sent32 < NRAND) && ($urandom_range(0, 3) != 0);
      a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
      or32 = ($urandom_range(0, 3) != 0);
      #1;
      if (ov16 && or16) begin
        e = (q16.size() > 0) ? q16.pop_front() : 64'hDEAD;
        check("rand16", pack(32'(s16), co16, of16), e);
        rcv16++;
      end
      if (ov32 && or32) begin
        e = (q32.size() > 0) ? q32.pop_front() : 64'hDEAD;
        check("rand32", pack(s32, co32, of32), e);
        rcv32++;
      end
      if (iv16 && ir16) begin
        q16.push_back(ref_add(16, 32'(a16), 32'(b16), c16));
        sent16++;
      end
      if (iv32 && ir32) begin
        q32.push_back(ref_add(32, a32, b32, c32));
        sent32++;
      end
    end
    check("rand16_count", 64'(rcv16), 64'(NRAND));
    check("rand32_count", 64'(rcv32), 64'(NRAND));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
